mgmt_bus_router: RTL and testbench

- Parametrised successor to the single-target management register path.
- Takes the byte-wide rd/wr management bus from the QSPI bridge and routes it to NUM_PORTS peripheral register blocks (regs, MAC stats, PHY/MDIO, etc.) by address window.
- Tracks one outstanding read, applies a response timeout, and records unmapped, timeout and overlap errors.
- Sits between the management bridge and all register interfaces in the management subsystem.

---
 rtl/mgmt_bus_pkg.sv | 23 ++
 rtl/mgmt_addr_decode.sv | 41 ++++
 rtl/mgmt_bus_router.sv | 252 +++++++++++++++++++++++++
 tb/tb_mgmt_bus_router.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mgmt_bus_pkg.sv
// Shared types and constants for the management bus router.
//   mgmt_rd_state_t : read FSM states
//   ERR_*           : bit positions in err_flags
//   sel_bits()      : width of the port-select field, at least 1
package mgmt_bus_pkg;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_WAIT = 1'b1
    } mgmt_rd_state_t;

    localparam int unsigned ERR_FLAG_W   = 3;
    localparam int unsigned ERR_UNMAPPED = 0;
    localparam int unsigned ERR_TIMEOUT  = 1;
    localparam int unsigned ERR_OVERLAP  = 2;

    // A single-port router still decodes one select bit so that address
    // windows above port 0 report as unmapped.
    function automatic int unsigned sel_bits(input int unsigned num_ports);
        return (num_ports <= 1) ? 1 : $clog2(num_ports);
    endfunction

endpackage

// File: rtl/mgmt_addr_decode.sv
// Combinational address decoder for one upstream path.
// Ports:
//   hi_addr_i   : upstream address bits above the per-port local window
//   mapped_c_o  : address falls in an existing port window
//   port_oh_c_o : one-hot port select, all-zero when unmapped
module mgmt_addr_decode
    import mgmt_bus_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned HI_WIDTH  = 6
) (
    input  logic [HI_WIDTH-1:0]  hi_addr_i,
    output logic                 mapped_c_o,
    output logic [NUM_PORTS-1:0] port_oh_c_o
);

    localparam int unsigned SEL_BITS = sel_bits(NUM_PORTS);

    logic [SEL_BITS-1:0] idx;
    logic                upper_zero;

    assign idx = hi_addr_i[SEL_BITS-1:0];

    // Any address bit above the select field must be clear to be mapped.
    if (HI_WIDTH > SEL_BITS) begin : g_upper
        assign upper_zero = ~|hi_addr_i[HI_WIDTH-1:SEL_BITS];
    end else begin : g_no_upper
        assign upper_zero = 1'b1;
    end

    assign mapped_c_o = upper_zero && (32'(idx) < NUM_PORTS);

    // One-hot expansion of the select field, gated by the mapped check.
    always_comb begin
        port_oh_c_o = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            port_oh_c_o[i] = mapped_c_o && (idx == SEL_BITS'(i));
        end
    end

endmodule

// File: rtl/mgmt_bus_router.sv
// Routes the byte-wide management rd/wr bus to NUM_PORTS register targets
// by address window, with one outstanding read, a response timeout and
// sticky error flags.
// Ports:
//   clk, rst                      : clock, async active-high reset
//   rd_en/rd_addr                 : upstream read request
//   rd_valid/rd_data              : upstream read response (data holds)
//   wr_en/wr_addr/wr_data         : upstream posted write
//   busy                          : read outstanding
//   p_rd_en/p_rd_addr             : one-hot downstream read strobe, address
//   p_rd_valid/p_rd_data          : downstream responses, port i at [8*i +: 8]
//   p_wr_en/p_wr_addr/p_wr_data   : one-hot downstream write strobe, payload
//   err_clear/err_flags           : sticky {overlap, timeout, unmapped}
// Optional build macro MGMT_BUS_ERR_CAPTURE_EN adds err_addr/err_addr_valid,
// holding the full upstream address of the first error since reset/clear.
module mgmt_bus_router
    import mgmt_bus_pkg::*;
#(
    parameter int unsigned NUM_PORTS        = 4,
    parameter int unsigned ADDR_WIDTH       = 16,
    parameter int unsigned LOCAL_ADDR_WIDTH = 10,
    parameter int unsigned TIMEOUT_CYCLES   = 255,
    parameter logic [7:0]  ERR_DATA         = 8'hff
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rd_en,
    input  logic [ADDR_WIDTH-1:0]       rd_addr,
    output logic                        rd_valid,
    output logic [7:0]                  rd_data,
    input  logic                        wr_en,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic [7:0]                  wr_data,
    output logic                        busy,
    output logic [NUM_PORTS-1:0]        p_rd_en,
    output logic [LOCAL_ADDR_WIDTH-1:0] p_rd_addr,
    input  logic [NUM_PORTS-1:0]        p_rd_valid,
    input  logic [8*NUM_PORTS-1:0]      p_rd_data,
    output logic [NUM_PORTS-1:0]        p_wr_en,
    output logic [LOCAL_ADDR_WIDTH-1:0] p_wr_addr,
    output logic [7:0]                  p_wr_data,
    input  logic                        err_clear,
    output logic [ERR_FLAG_W-1:0]       err_flags
`ifdef MGMT_BUS_ERR_CAPTURE_EN
    ,
    output logic [ADDR_WIDTH-1:0]       err_addr,
    output logic                        err_addr_valid
`endif
);

    localparam int unsigned HI_W  = ADDR_WIDTH - LOCAL_ADDR_WIDTH;
    localparam int unsigned CNT_W = 16;

    mgmt_rd_state_t              state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [NUM_PORTS-1:0]        sel_oh_q, sel_oh_d;
    logic [NUM_PORTS-1:0]        p_rd_en_q, p_rd_en_d;
    logic [LOCAL_ADDR_WIDTH-1:0] p_rd_addr_q, p_rd_addr_d;
    logic                        rd_valid_q, rd_valid_d;
    logic [7:0]                  rd_data_q, rd_data_d;
    logic [NUM_PORTS-1:0]        p_wr_en_q, p_wr_en_d;
    logic [LOCAL_ADDR_WIDTH-1:0] p_wr_addr_q, p_wr_addr_d;
    logic [7:0]                  p_wr_data_q, p_wr_data_d;
    logic [ERR_FLAG_W-1:0]       err_q, err_d;

    logic                 rd_mapped_c, wr_mapped_c;
    logic [NUM_PORTS-1:0] rd_oh_c, wr_oh_c;
    logic                 rd_hit_c;
    logic [7:0]           rd_mux_c;
    logic                 ev_rd_unmapped_c, ev_wr_unmapped_c;
    logic                 ev_overlap_c, ev_timeout_c;

    mgmt_addr_decode #(.NUM_PORTS(NUM_PORTS), .HI_WIDTH(HI_W)) u_rd_decode (
        .hi_addr_i   (rd_addr[ADDR_WIDTH-1:LOCAL_ADDR_WIDTH]),
        .mapped_c_o  (rd_mapped_c),
        .port_oh_c_o (rd_oh_c)
    );

    mgmt_addr_decode #(.NUM_PORTS(NUM_PORTS), .HI_WIDTH(HI_W)) u_wr_decode (
        .hi_addr_i   (wr_addr[ADDR_WIDTH-1:LOCAL_ADDR_WIDTH]),
        .mapped_c_o  (wr_mapped_c),
        .port_oh_c_o (wr_oh_c)
    );

    // Only the port that owns the outstanding read can complete it.
    assign rd_hit_c = |(p_rd_valid & sel_oh_q);

    always_comb begin
        rd_mux_c = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (sel_oh_q[i]) begin
                rd_mux_c = rd_mux_c | p_rd_data[8*i +: 8];
            end
        end
    end

    // Next-state logic: posted writes, read FSM, sticky errors.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        sel_oh_d         = sel_oh_q;
        p_rd_en_d        = '0;
        p_rd_addr_d      = p_rd_addr_q;
        rd_valid_d       = 1'b0;
        rd_data_d        = rd_data_q;
        p_wr_en_d        = '0;
        p_wr_addr_d      = p_wr_addr_q;
        p_wr_data_d      = p_wr_data_q;
        ev_rd_unmapped_c = 1'b0;
        ev_wr_unmapped_c = 1'b0;
        ev_overlap_c     = 1'b0;
        ev_timeout_c     = 1'b0;

        if (wr_en) begin
            if (wr_mapped_c) begin
                p_wr_en_d   = wr_oh_c;
                p_wr_addr_d = wr_addr[LOCAL_ADDR_WIDTH-1:0];
                p_wr_data_d = wr_data;
            end else begin
                ev_wr_unmapped_c = 1'b1;
            end
        end

        case (state_q)
            RD_IDLE: begin
                if (rd_en) begin
                    if (rd_mapped_c) begin
                        p_rd_en_d   = rd_oh_c;
                        p_rd_addr_d = rd_addr[LOCAL_ADDR_WIDTH-1:0];
                        sel_oh_d    = rd_oh_c;
                        cnt_d       = '0;
                        state_d     = RD_WAIT;
                    end else begin
                        rd_valid_d       = 1'b1;
                        rd_data_d        = 8'h00;
                        ev_rd_unmapped_c = 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                if (rd_en) begin
                    ev_overlap_c = 1'b1;
                end
                // A response arriving on the timeout cycle still wins.
                if (rd_hit_c) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = rd_mux_c;
                    cnt_d      = '0;
                    state_d    = RD_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    rd_valid_d   = 1'b1;
                    rd_data_d    = ERR_DATA;
                    ev_timeout_c = 1'b1;
                    cnt_d        = '0;
                    state_d      = RD_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = RD_IDLE;
        endcase

        // Clear first so that a same-cycle error keeps its flag set.
        err_d = err_clear ? '0 : err_q;
        if (ev_rd_unmapped_c || ev_wr_unmapped_c) err_d[ERR_UNMAPPED] = 1'b1;
        if (ev_timeout_c)                         err_d[ERR_TIMEOUT]  = 1'b1;
        if (ev_overlap_c)                         err_d[ERR_OVERLAP]  = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RD_IDLE;
            cnt_q       <= '0;
            sel_oh_q    <= '0;
            p_rd_en_q   <= '0;
            p_rd_addr_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            p_wr_en_q   <= '0;
            p_wr_addr_q <= '0;
            p_wr_data_q <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_oh_q    <= sel_oh_d;
            p_rd_en_q   <= p_rd_en_d;
            p_rd_addr_q <= p_rd_addr_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            p_wr_en_q   <= p_wr_en_d;
            p_wr_addr_q <= p_wr_addr_d;
            p_wr_data_q <= p_wr_data_d;
            err_q       <= err_d;
        end
    end

    assign busy      = (state_q == RD_WAIT);
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign p_rd_en   = p_rd_en_q;
    assign p_rd_addr = p_rd_addr_q;
    assign p_wr_en   = p_wr_en_q;
    assign p_wr_addr = p_wr_addr_q;
    assign p_wr_data = p_wr_data_q;
    assign err_flags = err_q;

`ifdef MGMT_BUS_ERR_CAPTURE_EN
    logic [ADDR_WIDTH-1:0] rd_addr_full_q, rd_addr_full_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic                  err_addr_valid_q, err_addr_valid_d;

    // First error since reset/clear is kept; same-cycle ties prefer the
    // new read request, then the write, then the timed-out read.
    always_comb begin
        rd_addr_full_d   = rd_addr_full_q;
        err_addr_d       = err_addr_q;
        err_addr_valid_d = err_addr_valid_q & ~err_clear;
        if ((state_q == RD_IDLE) && rd_en && rd_mapped_c) begin
            rd_addr_full_d = rd_addr;
        end
        if (!err_addr_valid_d) begin
            if (ev_overlap_c || ev_rd_unmapped_c) begin
                err_addr_d       = rd_addr;
                err_addr_valid_d = 1'b1;
            end else if (ev_wr_unmapped_c) begin
                err_addr_d       = wr_addr;
                err_addr_valid_d = 1'b1;
            end else if (ev_timeout_c) begin
                err_addr_d       = rd_addr_full_q;
                err_addr_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_full_q   <= '0;
            err_addr_q       <= '0;
            err_addr_valid_q <= 1'b0;
        end else begin
            rd_addr_full_q   <= rd_addr_full_d;
            err_addr_q       <= err_addr_d;
            err_addr_valid_q <= err_addr_valid_d;
        end
    end

    assign err_addr       = err_addr_q;
    assign err_addr_valid = err_addr_valid_q;
`endif

endmodule

// File: tb/tb_mgmt_bus_router.sv
// Bench for mgmt_bus_router: directed scenarios followed by randomized
// traffic, all checked against a transaction-level reference model.
module tb_mgmt_bus_router;

    localparam int unsigned NP = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned LW = 10;
    localparam int unsigned TO = 12;
    localparam logic [7:0]  ED = 8'hff;

    logic            clk = 1'b0;
    logic            rst;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic            rd_valid;
    logic [7:0]      rd_data;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [7:0]      wr_data;
    logic            busy;
    logic [NP-1:0]   p_rd_en;
    logic [LW-1:0]   p_rd_addr;
    logic [NP-1:0]   p_rd_valid;
    logic [8*NP-1:0] p_rd_data;
    logic [NP-1:0]   p_wr_en;
    logic [LW-1:0]   p_wr_addr;
    logic [7:0]      p_wr_data;
    logic            err_clear;
    logic [2:0]      err_flags;
`ifdef MGMT_BUS_ERR_CAPTURE_EN
    logic [AW-1:0]   err_addr;
    logic            err_addr_valid;
`endif

    mgmt_bus_router #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .LOCAL_ADDR_WIDTH(LW),
        .TIMEOUT_CYCLES(TO), .ERR_DATA(ED)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .p_rd_en(p_rd_en), .p_rd_addr(p_rd_addr),
        .p_rd_valid(p_rd_valid), .p_rd_data(p_rd_data),
        .p_wr_en(p_wr_en), .p_wr_addr(p_wr_addr), .p_wr_data(p_wr_data),
        .err_clear(err_clear), .err_flags(err_flags)
`ifdef MGMT_BUS_ERR_CAPTURE_EN
        , .err_addr(err_addr), .err_addr_valid(err_addr_valid)
`endif
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a read is outstanding from issue cycle until either
    // its port answers or TO cycles have elapsed since the downstream strobe.
    bit          m_busy;
    int          m_sel;
    int          m_issue;
    int          cyc;
    logic [2:0]  m_err;
    logic        x_rd_valid;
    logic [7:0]  x_rd_data;
    logic [3:0]  x_p_rd_en;
    logic [9:0]  x_p_rd_addr;
    logic [3:0]  x_p_wr_en;
    logic [9:0]  x_p_wr_addr;
    logic [7:0]  x_p_wr_data;

    task automatic model_reset();
        m_busy = 0; m_sel = 0; m_issue = 0; m_err = '0;
        x_rd_valid = 0; x_rd_data = '0; x_p_rd_en = '0; x_p_rd_addr = '0;
        x_p_wr_en = '0; x_p_wr_addr = '0; x_p_wr_data = '0;
    endtask

    task automatic model_step(input logic re, input logic [15:0] ra, input logic we,
                              input logic [15:0] wa, input logic [7:0] wd,
                              input logic [3:0] pv, input logic [31:0] pd, input logic ec);
        int rport, wport;
        logic [2:0] e;
        e = ec ? 3'b000 : m_err;
        x_rd_valid = 0; x_p_rd_en = '0; x_p_wr_en = '0;
        wport = int'(wa) / 1024;
        rport = int'(ra) / 1024;
        if (we) begin
            if (wport < int'(NP)) begin
                x_p_wr_en   = 4'(1 << wport);
                x_p_wr_addr = 10'(int'(wa) % 1024);
                x_p_wr_data = wd;
            end else e[0] = 1'b1;
        end
        if (m_busy) begin
            if (re) e[2] = 1'b1;
            if (pv[m_sel]) begin
                x_rd_valid = 1; x_rd_data = pd[8*m_sel +: 8]; m_busy = 0;
            end else if (cyc - m_issue == int'(TO)) begin
                x_rd_valid = 1; x_rd_data = ED; e[1] = 1'b1; m_busy = 0;
            end
        end else if (re) begin
            if (rport < int'(NP)) begin
                x_p_rd_en   = 4'(1 << rport);
                x_p_rd_addr = 10'(int'(ra) % 1024);
                m_busy = 1; m_sel = rport; m_issue = cyc + 1;
            end else begin
                x_rd_valid = 1; x_rd_data = 8'h00; e[0] = 1'b1;
            end
        end
        m_err = e;
        cyc++;
    endtask

    // Called at a negedge: drive one cycle of inputs, clock it, compare.
    task automatic step(input logic re, input logic [15:0] ra, input logic we,
                        input logic [15:0] wa, input logic [7:0] wd,
                        input logic [3:0] pv, input logic [31:0] pd, input logic ec);
        rd_en = re; rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd;
        p_rd_valid = pv; p_rd_data = pd; err_clear = ec;
        model_step(re, ra, we, wa, wd, pv, pd, ec);
        @(negedge clk);
        check("rd_valid",  32'(rd_valid),  32'(x_rd_valid));
        check("rd_data",   32'(rd_data),   32'(x_rd_data));
        check("busy",      32'(busy),      32'(m_busy));
        check("p_rd_en",   32'(p_rd_en),   32'(x_p_rd_en));
        check("p_wr_en",   32'(p_wr_en),   32'(x_p_wr_en));
        check("err_flags", 32'(err_flags), 32'(m_err));
        if (x_p_rd_en != '0) check("p_rd_addr", 32'(p_rd_addr), 32'(x_p_rd_addr));
        if (x_p_wr_en != '0) begin
            check("p_wr_addr", 32'(p_wr_addr), 32'(x_p_wr_addr));
            check("p_wr_data", 32'(p_wr_data), 32'(x_p_wr_data));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, '0, '0, $urandom, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_valid"}, 32'(rd_valid), 0);
        check({tag, "_rd_data"},  32'(rd_data),  0);
        check({tag, "_busy"},     32'(busy),     0);
        check({tag, "_p_rd_en"},  32'(p_rd_en),  0);
        check({tag, "_p_rd_addr"},32'(p_rd_addr),0);
        check({tag, "_p_wr_en"},  32'(p_wr_en),  0);
        check({tag, "_p_wr_addr"},32'(p_wr_addr),0);
        check({tag, "_p_wr_data"},32'(p_wr_data),0);
        check({tag, "_err"},      32'(err_flags),0);
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        a = 16'(($urandom_range(0, 5) << 10) | $urandom_range(0, 1023));
        if ($urandom_range(0, 7) == 0) a = a | 16'h8000;
        return a;
    endfunction

    initial begin
        rst = 1; rd_en = 0; rd_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
        p_rd_valid = '0; p_rd_data = '0; err_clear = 0;
        cyc = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 0;

        // Posted write to port 1
        step(0, '0, 1, 16'h0405, 8'h5a, '0, '0, 0);
        check("tp_wr_en",   32'(p_wr_en),   32'h2);
        check("tp_wr_addr", 32'(p_wr_addr), 32'h005);
        check("tp_wr_data", 32'(p_wr_data), 32'h5a);

        // Port 3 answers three cycles after its strobe
        step(1, 16'h0c10, 0, '0, '0, '0, '0, 0);
        check("tp_rd_en", 32'(p_rd_en), 32'h8);
        idle(3);
        step(0, '0, 0, '0, '0, 4'b1000, 32'h3c00_0000, 0);
        check("tp_rd_data", 32'(rd_data), 32'h3c);
        check("tp_busy_lo", 32'(busy),    0);

        // Unmapped read, then clear
        step(1, 16'h1000, 0, '0, '0, '0, '0, 0);
        check("tp_unmap_err", 32'(err_flags), 32'h1);
        step(0, '0, 0, '0, '0, '0, '0, 1);
        check("tp_clear", 32'(err_flags), 0);

        // Timeout on port 1, then a late response is ignored
        step(1, 16'h0400, 0, '0, '0, '0, '0, 0);
        idle(int'(TO) + 1);
        check("tp_to_data", 32'(rd_data),   32'hff);
        check("tp_to_err",  32'(err_flags), 32'h2);
        idle(1);
        step(0, '0, 0, '0, '0, 4'b0010, 32'h0000_5500, 0);
        check("tp_late", 32'(rd_valid), 0);

        // Overlapping read is dropped while a same-cycle write goes through
        step(0, '0, 0, '0, '0, '0, '0, 1);
        step(1, 16'h0800, 0, '0, '0, '0, '0, 0);
        step(1, 16'h0000, 1, 16'h0003, 8'h77, '0, '0, 0);
        check("tp_ovl_err", 32'(err_flags), 32'h4);
        check("tp_ovl_wr",  32'(p_wr_en),   32'h1);
        step(0, '0, 0, '0, '0, 4'b0100, 32'h00a5_0000, 0);
        check("tp_ovl_done", 32'(rd_data), 32'ha5);

        // Asynchronous reset while a read waits
        step(1, 16'h0401, 0, '0, '0, '0, '0, 0);
        idle(2);
        #2 rst = 1;
        #1 check_all_zero("midrst");
        model_reset();
        @(negedge clk);
        rst = 0;
        step(0, '0, 0, '0, '0, 4'b0010, 32'h0000_6600, 0);
        check("tp_rst_late", 32'(rd_valid), 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] pv;
            for (int b = 0; b < 4; b++) pv[b] = ($urandom_range(0, 9) == 0);
            step($urandom_range(0, 3) == 0, rand_addr(),
                 $urandom_range(0, 3) == 0, rand_addr(), 8'($urandom),
                 pv, $urandom, $urandom_range(0, 15) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
